uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter: DW, default 8, frame data width.
REQ-003 Parameter: BUSY_TO, default 4, maximum cycles from tx_valid to tx_busy=1 before abort.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester frame request; held high until gnt.
REQ-007 req_data  input  NREQ*DW  per-requester byte; slot i at bits [i*DW +: DW].
REQ-008 req_mask  input  NREQ  1 = requester enabled; masked requesters are never granted.
REQ-009 gnt  output  NREQ  one-hot one-cycle pulse; the byte is captured in that cycle.
REQ-010 done  output  NREQ  one-hot one-cycle pulse when the granted frame finishes.
REQ-011 err  output  1  one-cycle pulse on busy timeout abort.
REQ-012 tx_valid  output  1  one-cycle launch strobe to the UART transmitter.
REQ-013 tx_data  output  DW  byte to the transmitter.
REQ-014 tx_busy  input  1  transmitter busy, registered inside the transmitter.
REQ-015 owner  output  3  index of the current or last granted requester.

Function
REQ-016 The FSM SHALL use states ARB, LAUNCH, WAIT_HI and WAIT_LO.
- ARB: if tx_busy=0 and any (req & req_mask) is set -> LAUNCH.
- Otherwise stay in ARB.
REQ-017 In ARB, the winner SHALL be the first eligible index after the round-robin pointer, searching upward and wrapping NREQ-1 -> 0.
REQ-018 On ARB -> LAUNCH:
- gnt[winner]=1 for that cycle.
- req_data slot of the winner latched into tx_data.
- owner and pointer updated to the winner.
REQ-019 LAUNCH SHALL last exactly one cycle with tx_valid=1, then go to WAIT_HI with the timeout counter cleared.
REQ-020 WAIT_HI:
- tx_busy=1 -> WAIT_LO.
- Otherwise the counter increments.
- Counter reaching BUSY_TO -> ARB with err pulsed; no done; pointer keeps the aborted owner.
REQ-021 WAIT_LO: tx_busy=0 -> ARB with done[owner] pulsed in the transition cycle.
REQ-022 tx_data SHALL be held constant from LAUNCH until the next grant.
REQ-023 The next tx_valid SHALL NOT be issued earlier than the first ARB cycle after done or err.
- Back-to-back minimum: grant-to-grant = 3 + busy duration cycles.
REQ-024 Changes to req or req_mask after the grant SHALL NOT affect the frame in flight.
- A masked requester is ignored only at the next ARB evaluation.
REQ-025 A requester that keeps req high after gnt SHALL be granted again only after every other eligible requester has been served once.
REQ-026 tx_valid SHALL be asserted only in LAUNCH.
- gnt, done and err SHALL never be asserted together.
- At most one bit of gnt and of done SHALL be set.
REQ-027 tx_busy=1 while in ARB (external launch) SHALL block arbitration until it falls.
REQ-028 Counter width SHALL be clog2(BUSY_TO+1).
- Owner and pointer widths are 3 bits; indices >= NREQ are never produced.

Reset
REQ-029 On rst=0, immediately and asynchronously:
- State SHALL be ARB.
- Pointer = NREQ-1, so requester 0 wins first.
- owner=0, tx_data=0, timeout counter=0.
- gnt, done, err and tx_valid = 0.
REQ-030 Reset asserted mid-frame SHALL abort without a done pulse.
- After release, arbitration resumes only once tx_busy=0.

Verification
REQ-031 After reset, req=4'b1111, mask=4'b1111, model transmitter busy for 10 cycles -> gnt order 0,1,2,3,0; tx_data matches each slot; one done per grant.
REQ-032 req[2] only, data 8'hA5 -> gnt=4'b0100, tx_valid one cycle, tx_data=8'hA5; done=4'b0100 the cycle tx_busy falls.
REQ-033 tx_busy held 0 after launch, BUSY_TO=4 -> err pulse 5 cycles after tx_valid; no done; FSM back in ARB.
REQ-034 req=4'b1010, mask=4'b0010 -> only requester 1 is granted; requester 3 is never granted until its mask bit is set.
REQ-035 rst asserted in WAIT_LO -> all outputs 0 next sample; no done; first post-reset grant goes to the lowest eligible index.
REQ-036 tx_busy=1 externally while req=4'b0001 -> no gnt until tx_busy=0, then gnt=4'b0001 in the next cycle.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between the requesters, the arbiter and the UART transmitter.
interface uart_tx_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_mask;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               err;
  logic               tx_valid;
  logic [DW-1:0]      tx_data;
  logic               tx_busy;
  logic [2:0]         owner;

  // Arbiter side
  modport master (
    input  req, req_data, req_mask, tx_busy,
    output gnt, done, err, tx_valid, tx_data, owner
  );

  // Requester / transmitter side
  modport slave (
    output req, req_data, req_mask, tx_busy,
    input  gnt, done, err, tx_valid, tx_data, owner
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one UART transmitter between NREQ requesters.
// One frame in flight at a time; a transmitter that never reports busy is
// abandoned after BUSY_TO cycles with an err pulse.
//
// state   | meaning
// --------+----------------------------------------------------------
// ARB     | idle, pick next eligible requester once tx_busy is low
// LAUNCH  | one-cycle tx_valid strobe (gnt shown alongside)
// WAIT_HI | waiting for the transmitter to raise tx_busy, with timeout
// WAIT_LO | frame in progress, waiting for tx_busy to drop
module uart_tx_arb #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int BUSY_TO = 4
) (
  input logic            clk,
  input logic            rst,
  uart_tx_arb_if.master  bus
);

  localparam int CW = (BUSY_TO < 1) ? 1 : $clog2(BUSY_TO + 1);

  typedef enum logic [1:0] {ARB, LAUNCH, WAIT_HI, WAIT_LO} state_t;

  state_t          state_q;
  logic [2:0]      ptr_q;
  logic [2:0]      owner_q;
  logic [DW-1:0]   tx_data_q;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            err_q;
  logic            tx_valid_q;

  logic [NREQ-1:0] elig_d;
  logic            any_d;
  logic [2:0]      win_d;
  logic [DW-1:0]   win_data_d;

  // Winner search: smallest eligible index above the pointer, else wrap to the
  // smallest eligible index at or below it.
  always_comb begin
    elig_d     = bus.req & bus.req_mask;
    any_d      = |elig_d;
    win_d      = '0;
    win_data_d = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig_d[i] && (i <= int'(ptr_q))) win_d = 3'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig_d[i] && (i > int'(ptr_q))) win_d = 3'(i);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == win_d) win_data_d = bus.req_data[i*DW +: DW];
    end
  end

  // Sequencing FSM with registered strobes; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB;
      ptr_q      <= 3'(NREQ - 1);
      owner_q    <= '0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      case (state_q)
        ARB: begin
          if (!bus.tx_busy && any_d) begin
            gnt_q      <= NREQ'(1) << win_d;
            tx_valid_q <= 1'b1;
            tx_data_q  <= win_data_d;
            owner_q    <= win_d;
            ptr_q      <= win_d;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt_q   <= '0;
          state_q <= WAIT_HI;
        end
        WAIT_HI: begin
          if (bus.tx_busy) begin
            state_q <= WAIT_LO;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(BUSY_TO - 1)) begin
              err_q   <= 1'b1;
              state_q <= ARB;
            end
          end
        end
        WAIT_LO: begin
          if (!bus.tx_busy) begin
            done_q  <= NREQ'(1) << owner_q;
            state_q <= ARB;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: stimulus pushes expected grants, dones and
// errors; a negedge monitor pops and compares whenever the DUT pulses.
module tb_uart_tx_arb;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  typedef struct {
    logic [3:0] vec;
    logic [7:0] data;
    int         idx;
    int         gap;
  } gexp_t;

  typedef struct {
    logic [3:0] vec;
    int         dly;
  } dexp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy_m = 1'b0;
  logic busy_f = 1'b0;
  logic model_en = 1'b1;
  int   busy_len = 10;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gnt_seen = 0;
  int last_gnt_cyc = 0;
  logic [7:0] hold_data = '0;
  logic       have_hold = 1'b0;

  gexp_t gq[$];
  dexp_t dq[$];
  int    eq[$];

  uart_tx_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

  uart_tx_arb #(.NREQ(NREQ), .DW(DW), .BUSY_TO(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.tx_busy = busy_m | busy_f;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter model: busy rises the cycle after tx_valid, lasts busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_valid && model_en) begin
        @(posedge clk);
        #1 busy_m = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 busy_m = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    gexp_t g;
    dexp_t d;
    int    e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        have_hold = 1'b0;
      end else begin
        if ((bus.gnt != 0) + (bus.done != 0) + bus.err > 1)
          chk("exclusive_pulses", {bus.gnt, bus.done, 3'b0, bus.err}, 0);
        if (bus.tx_valid && bus.gnt == 0) chk("tx_valid_without_gnt", 1, 0);
        if (bus.gnt != 0) begin
          gnt_seen++;
          if (gq.size() == 0) begin
            chk("unexpected_gnt", 32'(bus.gnt), 0);
          end else begin
            g = gq.pop_front();
            chk("gnt", 32'(bus.gnt), 32'(g.vec));
            chk("tx_data", 32'(bus.tx_data), 32'(g.data));
            chk("owner", 32'(bus.owner), g.idx);
            chk("tx_valid", 32'(bus.tx_valid), 1);
            if (g.gap != 0) chk("gnt_gap", cyc - last_gnt_cyc, g.gap);
            hold_data = g.data;
            have_hold = 1'b1;
          end
          last_gnt_cyc = cyc;
        end else if (have_hold) begin
          chk("tx_data_hold", 32'(bus.tx_data), 32'(hold_data));
        end
        if (bus.done != 0) begin
          if (dq.size() == 0) begin
            chk("unexpected_done", 32'(bus.done), 0);
          end else begin
            d = dq.pop_front();
            chk("done", 32'(bus.done), 32'(d.vec));
            chk("done_delay", cyc - last_gnt_cyc, d.dly);
          end
        end
        if (bus.err) begin
          if (eq.size() == 0) begin
            chk("unexpected_err", 1, 0);
          end else begin
            e = eq.pop_front();
            chk("err_delay", cyc - last_gnt_cyc, e);
          end
        end
      end
    end
  end

  task automatic push_g(input logic [3:0] vec, input logic [7:0] data, input int idx, input int gap);
    gexp_t g;
    g.vec = vec; g.data = data; g.idx = idx; g.gap = gap;
    gq.push_back(g);
  endtask

  task automatic push_d(input logic [3:0] vec, input int dly);
    dexp_t d;
    d.vec = vec; d.dly = dly;
    dq.push_back(d);
  endtask

  task automatic wait_gnts(input int n, input int budget);
    int start;
    int k;
    start = gnt_seen;
    k = 0;
    while (gnt_seen < start + n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (gnt_seen < start + n) chk("timeout_gnt", gnt_seen - start, n);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((gq.size() + dq.size() + eq.size()) != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if ((gq.size() + dq.size() + eq.size()) != 0)
      chk("timeout_idle", gq.size() + dq.size() + eq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req      = '0;
    bus.req_mask = 4'b1111;
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // All four requesting: round robin 0,1,2,3,0 at 3+busy spacing
    busy_len = 10;
    push_g(4'b0001, 8'h11, 0, 0);  push_d(4'b0001, 12);
    push_g(4'b0010, 8'h22, 1, 13); push_d(4'b0010, 12);
    push_g(4'b0100, 8'h33, 2, 13); push_d(4'b0100, 12);
    push_g(4'b1000, 8'h44, 3, 13); push_d(4'b1000, 12);
    push_g(4'b0001, 8'h11, 0, 13); push_d(4'b0001, 12);
    bus.req = 4'b1111;
    wait_gnts(5, 200);
    bus.req = '0;
    wait_idle(100);

    // Single requester 2 with 0xA5
    busy_len = 3;
    bus.req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    push_g(4'b0100, 8'hA5, 2, 0); push_d(4'b0100, 5);
    bus.req = 4'b0100;
    wait_gnts(1, 50);
    bus.req = '0;
    wait_idle(50);

    // Transmitter never goes busy: err 5 cycles after tx_valid, no done
    model_en = 1'b0;
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h5A};
    push_g(4'b0001, 8'h5A, 0, 0);
    eq.push_back(5);
    bus.req = 4'b0001;
    wait_gnts(1, 50);
    bus.req = '0;
    wait_idle(50);
    model_en = 1'b1;

    // Mask: only requester 1 until requester 3 is unmasked
    busy_len = 2;
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req_mask = 4'b0010;
    push_g(4'b0010, 8'h22, 1, 0); push_d(4'b0010, 4);
    bus.req = 4'b1010;
    wait_gnts(1, 50);
    bus.req = 4'b1000;
    wait_idle(50);
    repeat (20) @(negedge clk);
    push_g(4'b1000, 8'h44, 3, 0); push_d(4'b1000, 4);
    bus.req_mask = 4'b1010;
    wait_gnts(1, 50);
    bus.req = '0;
    wait_idle(50);
    bus.req_mask = 4'b1111;

    // External busy blocks arbitration; grant the cycle after it drops
    busy_f = 1'b1;
    bus.req = 4'b0001;
    repeat (8) @(negedge clk);
    push_g(4'b0001, 8'h11, 0, 0); push_d(4'b0001, 4);
    busy_f = 1'b0;
    @(negedge clk);
    chk("gnt_after_ext_busy", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    wait_idle(50);

    // Reset during WAIT_LO: no done, outputs cleared, restart at lowest eligible
    busy_len = 10;
    push_g(4'b0100, 8'h33, 2, 0);
    bus.req = 4'b0100;
    wait_gnts(1, 50);
    bus.req = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(bus.gnt), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_err", 32'(bus.err), 0);
    chk("mid_rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("mid_rst_owner", 32'(bus.owner), 0);
    chk("mid_rst_tx_data", 32'(bus.tx_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_g(4'b0100, 8'h33, 2, 0); push_d(4'b0100, 12);
    bus.req = 4'b1100;
    for (int k = 0; k < 20 && busy_m; k++) begin
      @(negedge clk);
      chk("gnt_while_busy_after_rst", 32'(bus.gnt), 0);
    end
    wait_gnts(1, 50);
    bus.req = '0;
    wait_idle(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
